ov5640_dvp_tx: RTL and testbench

- Camera-side DVP transmitter that emulates an OV5640 sensor output.
- Accepts 24-bit pixels on a ready/valid stream with start-of-frame and end-of-line markers.
- Serialises each pixel into three bytes on d[7:0] with vsync/href framing.
- Drives the capture path in loopback benches and feeds synthetic video into the board-level DVP pins.
- All outputs are registered in the pclk domain; pclk itself is forwarded to the pins externally.

---
 rtl/ov5640_dvp_tx.sv | 128 ++++++++++++
 tb/tb_ov5640_dvp_tx.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ov5640_dvp_tx.sv
// ov5640_dvp_tx: OV5640-style DVP transmitter, 24-bit ready/valid pixels out as 3 bytes/pixel with vsync/href framing
//   pclk, rst (async, active high), en (frame start permit, IDLE only)
//   s_tdata/s_tvalid/s_tready/s_tuser(SOF)/s_tlast(EOL) : pixel stream in
//   vsync, href, d[7:0] : registered DVP outputs; underrun, sync_err : one-cycle error pulses
module ov5640_dvp_tx #(
   parameter int H_ACTIVE  = 640,
   parameter int V_ACTIVE  = 480,
   parameter int VSYNC_LEN = 8,
   parameter int V_FRONT   = 16,
   parameter int H_BLANK   = 32,
   parameter int V_BACK    = 16
) (
   input  logic        pclk,
   input  logic        rst,
   input  logic        en,
   input  logic [23:0] s_tdata,
   input  logic        s_tvalid,
   output logic        s_tready,
   input  logic        s_tuser,
   input  logic        s_tlast,
   output logic        vsync,
   output logic        href,
   output logic [7:0]  d,
   output logic        underrun,
   output logic        sync_err
);
   localparam int PW = H_ACTIVE > 1 ? $clog2(H_ACTIVE) : 1;
   localparam int LW = V_ACTIVE > 1 ? $clog2(V_ACTIVE) : 1;
   localparam int M1 = VSYNC_LEN > V_FRONT ? VSYNC_LEN : V_FRONT;
   localparam int M2 = H_BLANK > V_BACK ? H_BLANK : V_BACK;
   localparam int CW = $clog2((M1 > M2 ? M1 : M2) + 1);
   typedef enum logic [2:0] {IDLE, VSYNC, VFRONT, LINE, HBLANK, VBACK} state_t;
   state_t st, st_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [1:0] ph, ph_n;
   logic [PW-1:0] pix, pix_n;
   logic [LW-1:0] line, line_n;
   logic full, h_user, h_last;
   logic [23:0] h_data;
   logic [15:0] sh;
   logic load, consume, err;
   // counters describe the cycle currently on the pins; the *_n values describe the
   // cycle being registered next, so outputs line up with the state they belong to
   always_comb begin
      st_n = st;
      cnt_n = cnt + 1'b1;
      ph_n = ph;
      pix_n = pix;
      line_n = line;
      case (st)
         IDLE: begin
            cnt_n = '0;
            if (full && h_user && en) begin
               st_n = VSYNC;
               line_n = '0;
            end
         end
         VSYNC: if (cnt == CW'(VSYNC_LEN - 1)) begin
            st_n = VFRONT;
            cnt_n = '0;
         end
         VFRONT: if (cnt == CW'(V_FRONT - 1)) st_n = LINE;
         LINE: begin
            cnt_n = '0;
            ph_n = ph == 2'd2 ? 2'd0 : ph + 2'd1;
            if (ph == 2'd2) begin
               pix_n = pix + 1'b1;
               if (pix == PW'(H_ACTIVE - 1)) begin
                  pix_n = '0;
                  if (line == LW'(V_ACTIVE - 1)) st_n = VBACK;
                  else begin
                     st_n = HBLANK;
                     line_n = line + 1'b1;
                  end
               end
            end
         end
         HBLANK: if (cnt == CW'(H_BLANK - 1)) st_n = LINE;
         VBACK: if (cnt == CW'(V_BACK - 1)) st_n = IDLE;
         default: st_n = IDLE;
      endcase
   end
   // a pixel is taken from the holding register whenever byte 0 of a pixel is about to be driven;
   // in IDLE anything that is not a start-of-frame pixel is discarded
   assign load = st_n == LINE && ph_n == 2'd0;
   assign consume = full && (load || (st == IDLE && !h_user));
   assign s_tready = !full || consume;
   assign err = load && full && ((h_last != (pix_n == PW'(H_ACTIVE - 1))) ||
                                 (h_user && !(line_n == '0 && pix_n == '0)));
   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         st <= IDLE;
         cnt <= '0;
         ph <= '0;
         pix <= '0;
         line <= '0;
         full <= 1'b0;
         h_data <= '0;
         h_user <= 1'b0;
         h_last <= 1'b0;
         sh <= '0;
         vsync <= 1'b0;
         href <= 1'b0;
         d <= 8'h00;
         underrun <= 1'b0;
         sync_err <= 1'b0;
      end else begin
         st <= st_n;
         cnt <= cnt_n;
         ph <= ph_n;
         pix <= pix_n;
         line <= line_n;
         if (s_tvalid && s_tready) begin
            full <= 1'b1;
            h_data <= s_tdata;
            h_user <= s_tuser;
            h_last <= s_tlast;
         end else if (consume) full <= 1'b0;
         // an empty register at byte 0 loads zeros so the whole pixel goes out as 00,00,00
         if (load) sh <= full ? h_data[15:0] : 16'h0000;
         vsync <= st_n == VSYNC;
         href <= st_n == LINE;
         d <= st_n != LINE ? 8'h00 : load ? (full ? h_data[23:16] : 8'h00) : ph_n == 2'd1 ? sh[15:8] : sh[7:0];
         underrun <= load && !full;
         sync_err <= err;
      end
   end
endmodule

// File: tb/tb_ov5640_dvp_tx.sv
// tb_ov5640_dvp_tx: directed self-checking bench for ov5640_dvp_tx with small frame parameters
module tb_ov5640_dvp_tx;
   logic pclk = 1'b0;
   logic rst = 1'b1;
   logic en = 1'b1;
   logic [23:0] s_tdata = '0;
   logic s_tvalid = 1'b0;
   logic s_tuser = 1'b0;
   logic s_tlast = 1'b0;
   logic s_tready, vsync, href, underrun, sync_err;
   logic [7:0] d;
   ov5640_dvp_tx #(.H_ACTIVE(4), .V_ACTIVE(2), .VSYNC_LEN(3), .V_FRONT(2), .H_BLANK(5), .V_BACK(2)) dut (
      .pclk(pclk), .rst(rst), .en(en), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
      .s_tuser(s_tuser), .s_tlast(s_tlast), .vsync(vsync), .href(href), .d(d),
      .underrun(underrun), .sync_err(sync_err)
   );
   always #5 pclk = ~pclk;
   int cyc = 0;
   always @(posedge pclk) cyc <= cyc + 1;
   typedef struct {
      logic [23:0] d;
      logic u;
      logic l;
      int gap;
   } px_t;
   px_t q[$];
   logic [23:0] slot[8];
   logic [11:0] rec[40];
   int n_chk = 0;
   int n_fail = 0;
   int sof_cyc = -1;
   int vs_cyc = -1;
   bit stop_feed = 1'b0;
   function automatic logic [23:0] pval(int k);
      return {8'(3 * k + 1), 8'(3 * k + 2), 8'(3 * k + 3)};
   endfunction
   // reference frame, index 0 = first vsync cycle: vsync 0-2, front 3-4, line0 5-16,
   // hblank 17-21, line1 22-33, vback 34-35, idle after; packed {vsync,href,underrun,sync_err,d}
   function automatic logic [11:0] expv(int i, int ui, int si);
      logic h;
      int off, px;
      logic [23:0] w;
      logic [7:0] b;
      h = (i >= 5 && i < 17) || (i >= 22 && i < 34);
      b = 8'h00;
      if (h) begin
         off = i < 17 ? i - 5 : i - 22;
         px = (i < 17 ? 0 : 4) + off / 3;
         w = slot[px];
         b = off % 3 == 0 ? w[23:16] : off % 3 == 1 ? w[15:8] : w[7:0];
      end
      return {i < 3, h, i == ui, i == si, b};
   endfunction
   task automatic push_std(int skip, int gap_at, int gap, logic [7:0] lmask);
      for (int k = 0; k < 8; k++) begin
         px_t p;
         p.d = pval(k);
         p.u = k == 0;
         p.l = lmask[k];
         p.gap = k == gap_at ? gap : 0;
         slot[k] = k == skip ? 24'h0 : pval(k);
         if (k != skip) q.push_back(p);
      end
   endtask
   task automatic feed();
      logic acc;
      int w;
      acc = 1'b0;
      w = -1;
      for (int t = 0; t < 400 && !stop_feed; t++) begin
         @(negedge pclk);
         if (acc) begin
            if (q[0].u) sof_cyc = cyc;
            void'(q.pop_front());
            acc = 1'b0;
            w = -1;
         end
         if (q.size() == 0 || stop_feed) break;
         if (w < 0) w = q[0].gap;
         if (w > 0) begin
            s_tvalid = 1'b0;
            w--;
         end else begin
            s_tvalid = 1'b1;
            s_tdata = q[0].d;
            s_tuser = q[0].u;
            s_tlast = q[0].l;
            #1 acc = s_tready;
         end
      end
      s_tvalid = 1'b0;
      s_tuser = 1'b0;
      s_tlast = 1'b0;
   endtask
   task automatic capture(output bit ok);
      ok = 1'b0;
      for (int t = 0; t < 200; t++) begin
         @(negedge pclk);
         if (vsync) begin
            ok = 1'b1;
            break;
         end
      end
      if (ok) begin
         vs_cyc = cyc;
         for (int i = 0; i < 40; i++) begin
            if (i > 0) @(negedge pclk);
            rec[i] = {vsync, href, underrun, sync_err, d};
         end
      end
   endtask
   task automatic run_frame(output bit ok);
      fork
         feed();
         capture(ok);
      join
      q.delete();
   endtask
   task automatic test_reset();
      repeat (3) @(negedge pclk);
      n_chk++;
      if ({vsync, href, underrun, sync_err, d} !== 12'h000) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h want 000", {vsync, href, underrun, sync_err, d});
      end
      n_chk++;
      if (s_tready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_tready: got %b want 1", s_tready);
      end
      rst = 1'b0;
      repeat (2) @(negedge pclk);
   endtask
   task automatic test_frame();
      bit ok;
      push_std(-1, -1, 0, 8'b1000_1000);
      run_frame(ok);
      n_chk++;
      if (!ok) begin
         n_fail++;
         $display("FAIL frame_vsync: vsync never rose within bound");
      end
      for (int i = 0; i < 40; i++) begin
         n_chk++;
         if (rec[i] !== expv(i, -1, -1)) begin
            n_fail++;
            $display("FAIL frame_cycle %0d: got %h want %h", i, rec[i], expv(i, -1, -1));
         end
      end
      n_chk++;
      if (vs_cyc !== sof_cyc + 1) begin
         n_fail++;
         $display("FAIL frame_vsync_latency: vsync at %0d want %0d", vs_cyc, sof_cyc + 1);
      end
   endtask
   task automatic test_loopback();
      bit ok;
      logic [23:0] w;
      logic [23:0] got[$];
      int k, errs;
      push_std(-1, -1, 0, 8'b1000_1000);
      run_frame(ok);
      w = '0;
      k = 0;
      errs = 0;
      for (int i = 0; i < 40; i++) begin
         if (rec[i][10]) begin
            w = {w[15:0], rec[i][7:0]};
            k++;
            if (k % 3 == 0) got.push_back(w);
         end
         if (rec[i][9] || rec[i][8]) errs++;
      end
      n_chk++;
      if (got.size() !== 8) begin
         n_fail++;
         $display("FAIL loopback_count: got %0d words want 8", got.size());
      end
      for (int i = 0; i < 8 && i < got.size(); i++) begin
         n_chk++;
         if (got[i] !== pval(i)) begin
            n_fail++;
            $display("FAIL loopback_word %0d: got %h want %h", i, got[i], pval(i));
         end
      end
      n_chk++;
      if (errs !== 0) begin
         n_fail++;
         $display("FAIL loopback_errors: got %0d error pulses want 0", errs);
      end
   endtask
   task automatic test_underrun();
      bit ok;
      push_std(2, 3, 7, 8'b1000_1000);
      run_frame(ok);
      n_chk++;
      if (!ok) begin
         n_fail++;
         $display("FAIL underrun_vsync: vsync never rose within bound");
      end
      for (int i = 0; i < 40; i++) begin
         n_chk++;
         if (rec[i] !== expv(i, 11, -1)) begin
            n_fail++;
            $display("FAIL underrun_cycle %0d: got %h want %h", i, rec[i], expv(i, 11, -1));
         end
      end
   endtask
   task automatic test_drop();
      bit ok;
      px_t p;
      p.u = 1'b0;
      p.l = 1'b0;
      p.gap = 0;
      p.d = 24'hAAAAAA;
      q.push_back(p);
      p.d = 24'hBBBBBB;
      q.push_back(p);
      push_std(-1, -1, 0, 8'b1000_1000);
      run_frame(ok);
      n_chk++;
      if (vs_cyc !== sof_cyc + 1) begin
         n_fail++;
         $display("FAIL drop_vsync_latency: vsync at %0d want %0d", vs_cyc, sof_cyc + 1);
      end
      for (int i = 0; i < 40; i++) begin
         n_chk++;
         if (rec[i] !== expv(i, -1, -1)) begin
            n_fail++;
            $display("FAIL drop_cycle %0d: got %h want %h", i, rec[i], expv(i, -1, -1));
         end
      end
   endtask
   task automatic test_sync_err();
      bit ok;
      push_std(-1, -1, 0, 8'b1000_1100);
      run_frame(ok);
      n_chk++;
      if (!ok) begin
         n_fail++;
         $display("FAIL syncerr_vsync: vsync never rose within bound");
      end
      for (int i = 0; i < 40; i++) begin
         n_chk++;
         if (rec[i] !== expv(i, -1, 11)) begin
            n_fail++;
            $display("FAIL syncerr_cycle %0d: got %h want %h", i, rec[i], expv(i, -1, 11));
         end
      end
   endtask
   task automatic test_reset_mid();
      bit ok, seen;
      push_std(-1, -1, 0, 8'b1000_1000);
      seen = 1'b0;
      fork
         feed();
         begin
            for (int t = 0; t < 200 && !seen; t++) begin
               @(negedge pclk);
               seen = vsync;
            end
            repeat (9) @(negedge pclk);
            n_chk++;
            if ({href, d} !== 9'h105) begin
               n_fail++;
               $display("FAIL midrst_byte5: got %h want 105", {href, d});
            end
            #2 rst = 1'b1;
            stop_feed = 1'b1;
            s_tvalid = 1'b0;
            #1;
            n_chk++;
            if ({vsync, href, underrun, sync_err, d} !== 12'h000) begin
               n_fail++;
               $display("FAIL midrst_outputs: got %h want 000", {vsync, href, underrun, sync_err, d});
            end
            n_chk++;
            if (s_tready !== 1'b1) begin
               n_fail++;
               $display("FAIL midrst_tready: got %b want 1", s_tready);
            end
         end
      join
      q.delete();
      repeat (2) @(negedge pclk);
      rst = 1'b0;
      stop_feed = 1'b0;
      @(negedge pclk);
      push_std(-1, -1, 0, 8'b1000_1000);
      run_frame(ok);
      n_chk++;
      if (vs_cyc !== sof_cyc + 1) begin
         n_fail++;
         $display("FAIL midrst_vsync_latency: vsync at %0d want %0d", vs_cyc, sof_cyc + 1);
      end
      for (int i = 0; i < 40; i++) begin
         n_chk++;
         if (rec[i] !== expv(i, -1, -1)) begin
            n_fail++;
            $display("FAIL midrst_cycle %0d: got %h want %h", i, rec[i], expv(i, -1, -1));
         end
      end
   endtask
   initial begin
      test_reset();
      test_frame();
      test_loopback();
      test_underrun();
      test_drop();
      test_sync_err();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end
endmodule
